mem_wait: RTL and testbench
===========================

Name: mem_wait

Overview:
- Parametrised successor to the single-port `mem` used by the zktc core.
- Byte-addressed RAM with configurable data width, per-byte write strobes and a programmable wait-state count, behind the core's vaild/ready handshake.
- Adds an `err` response for out-of-range and misaligned accesses, plus synchronous reset of the handshake logic.
- Sits between the core's memory interface and storage; lets software and benches model slow memory.

Parameters:
- DATA_WIDTH, 16, bus width in bits; multiple of 8, range 16..64.
- ADDR_WIDTH, 16, byte-address width.
- MEM_SIZE, 16'h5000, storage size in bytes; multiple of DATA_WIDTH/8.
- WAIT_CYCLES, 1, extra clocks between accept and response; 0..15.
- INIT_FILE, "", optional $readmemh image; empty means contents are undefined at power-up.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- vaild  in  1  request valid; name matches the existing core bus.
- wstrb  in  DATA_WIDTH/8  byte-lane write enables; all zero means read.
- addr  in  ADDR_WIDTH  byte address.
- din  in  DATA_WIDTH  write data; lane i is din[8i+7:8i].
- dout  out  DATA_WIDTH  read data.
- ready  out  1  response valid.
- err  out  1  access error; qualified by ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state becomes IDLE; ready=0, err=0, dout=0; wait counter cleared.
  - Storage contents are not cleared.
  - Reset mid-transaction abandons it with no write.
- Word index = addr >> log2(DATA_WIDTH/8).
- Misaligned: addr low log2(DATA_WIDTH/8) bits nonzero.
- Out of range: addr >= MEM_SIZE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With vaild=1, capture addr/wstrb/din and load cnt=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else straight to RESP.
- WAIT:
  - cnt decrements each clock; at cnt==1, go to RESP.
  - If vaild drops in WAIT, return to IDLE: no write, ready never asserts.
- Entering RESP (single edge), for a good access:
  - Write: each lane with captured wstrb[i]=1 is written; other lanes unchanged. dout is not updated.
  - Read: dout gets the word at the index.
- Entering RESP, for a bad access (misaligned or out of range):
  - err=1; no write; a read returns dout=0.
- RESP:
  - ready=1 and err are held while vaild=1.
  - When vaild is sampled 0, go to IDLE; ready and err go to 0 on that edge.
  - A new request needs vaild low for at least one edge, so a held vaild never double-issues.
- Latency: ready is high WAIT_CYCLES+1 clocks after the accepting edge (WAIT_CYCLES=0 means the next edge).
- dout holds its last read value through writes, errors and IDLE until the next successful read.
- Captured request fields are stable from accept through RESP; bus changes after accept are ignored.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Decomposition:
- Package mem_pkg:
  - state enum `mem_state_t` {IDLE, WAIT, RESP}.
  - localparam function `strb_w(DATA_WIDTH)` = DATA_WIDTH/8.
  - `off_w` = $clog2(strb_w).
- One sub-module `mem_array`:
  - Storage as MEM_SIZE/strb_w words, one synchronous write port with byte enables, one read port.
  - Optional INIT_FILE load.
- FSM, counter, address checks and output registers live in mem_wait.

Test Plan:
- WAIT_CYCLES=1, DATA_WIDTH=16: write 16'hdead at 0x0000 (wstrb 2'b11), then read 0x0000 -> ready rises 2 clocks after accept, dout=16'hdead, err=0.
- Byte lanes: write 16'hbeef at 0x0002 (2'b11), write 16'h12xx with wstrb 2'b10, then read -> dout=16'h12ef.
- Out of range and misaligned:
  - read 0x5000 -> ready=1, err=1, dout=0.
  - write 0x0001 (2'b11) -> err=1, and a following read of 0x0000 is unchanged.
- Abort and hold:
  - WAIT_CYCLES=3, drop vaild after 2 clocks of a write of 16'hcafe to 0x0004 -> ready never rises; a later read returns the old value.
  - Hold vaild 10 clocks on one read -> exactly one transaction, ready stays high until vaild falls.
- Reset mid-WAIT during a write to 0x0006 -> next edge ready=0, err=0, dout=0; the location is not written.
- WAIT_CYCLES=0, DATA_WIDTH=32: write 32'h01234567 at 0x0008, read -> ready 1 clock after accept, dout=32'h01234567.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory block.
// Holds the handshake FSM state type and helpers that derive the
// byte-lane count and byte-offset width from the data bus width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Number of byte lanes on a data bus of the given width.
  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside one word.
  function automatic int off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised storage for mem_wait.
// Ports:
//   clk    - rising-edge clock for the write port
//   we     - write enable, qualified per lane by wstrb
//   wstrb  - byte-lane enables for the write
//   idx    - word index shared by the read and write ports
//   wdata  - write data, lane i is wdata[8i+7:8i]
//   rdata  - combinational read of the word at idx
module mem_array
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 16,
  parameter int    MEM_SIZE   = 16'h5000,
  parameter int    IDX_W      = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [strb_w(DATA_WIDTH)-1:0] wstrb,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int WORDS  = MEM_SIZE / STRB_W;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Byte-masked write: lanes without a strobe keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_wait.sv
// Byte-addressed RAM behind the core's vaild/ready handshake with a
// programmable number of wait states and an error response.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset of the handshake logic
//   vaild  - request valid (spelling matches the core bus)
//   wstrb  - byte-lane write enables, all zero means read
//   addr   - byte address
//   din    - write data
//   dout   - read data, held until the next successful read
//   ready  - response valid, held while vaild stays high
//   err    - misaligned or out-of-range access, qualified by ready
module mem_wait
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH  = 16,
  parameter int    ADDR_WIDTH  = 16,
  parameter int    MEM_SIZE    = 16'h5000,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vaild,
  input  logic [strb_w(DATA_WIDTH)-1:0] wstrb,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          ready,
  output logic                          err
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int OFF_W  = off_w(DATA_WIDTH);
  localparam int WORDS  = MEM_SIZE / STRB_W;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  mem_state_t state, state_next;
  logic [3:0] cnt;
  logic       bad_q;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [STRB_W-1:0]     req_wstrb;
  logic [DATA_WIDTH-1:0] req_din;
  logic                  req_bad;
  logic                  req_read;
  logic                  enter_resp;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // With zero wait states the access happens on the accepting edge
  // itself, before the capture registers hold the request, so the
  // live bus is used while still in IDLE.
  always_comb begin
    req_addr  = addr_q;
    req_wstrb = wstrb_q;
    req_din   = din_q;
    if (state == IDLE) begin
      req_addr  = addr;
      req_wstrb = wstrb;
      req_din   = din;
    end
  end

  assign req_bad  = (req_addr[OFF_W-1:0] != '0) ||
                    (32'(req_addr) >= 32'(MEM_SIZE));
  assign req_read = (req_wstrb == '0);

  // Next-state logic; dropping vaild anywhere after accept returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (vaild) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!vaild)           state_next = IDLE;
        else if (cnt == 4'd1) state_next = RESP;
      end
      RESP: if (!vaild) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_next == RESP);
  assign mem_we     = rst_n && enter_resp && !req_bad && !req_read;

  // Request capture; fields stay frozen from accept until the next accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && vaild) begin
      addr_q  <= addr;
      wstrb_q <= wstrb;
      din_q   <= din;
    end
  end

  // Handshake state, wait counter and response registers. The access
  // resolves on the edge into RESP; ready and err follow one edge later
  // and drop on the edge that sees vaild low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      bad_q <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && vaild) cnt <= WAIT_LOAD;
      else if (state == WAIT)     cnt <= cnt - 4'd1;

      if (enter_resp) begin
        bad_q <= req_bad;
        if (req_read) dout <= req_bad ? '0 : rd_data;
      end

      if (state == RESP && vaild) begin
        ready <= 1'b1;
        err   <= bad_q;
      end else begin
        ready <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wstrb (req_wstrb),
    .idx   (req_addr[OFF_W +: IDX_W]),
    .wdata (req_din),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mem_wait.sv
// Bench for mem_wait: three instances (16-bit/1 wait, 16-bit/3 waits,
// 32-bit/0 waits) share one request bus; sel picks which one sees vaild.
module tb_mem_wait;

  logic        clk;
  logic        rst_n;
  logic        vaild;
  logic [15:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] din;
  int          sel;

  logic        vaild0, vaild1, vaild2;
  logic [15:0] dout0, dout1;
  logic [31:0] dout2;
  logic        ready0, ready1, ready2;
  logic        err0, err1, err2;

  logic [31:0] obs_dout;
  logic        obs_ready;
  logic        obs_err;

  int tests;
  int fails;

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] din;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  typedef struct {
    string       name;
    int          lat;
    logic        err;
    logic [31:0] dout;
  } exp_t;

  vec_t vecs [22];
  exp_t exp_q [$];

  assign vaild0 = vaild && (sel == 0);
  assign vaild1 = vaild && (sel == 1);
  assign vaild2 = vaild && (sel == 2);

  mem_wait #(.DATA_WIDTH(16), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .vaild(vaild0), .wstrb(wstrb[1:0]),
    .addr(addr), .din(din[15:0]), .dout(dout0), .ready(ready0), .err(err0)
  );

  mem_wait #(.DATA_WIDTH(16), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .vaild(vaild1), .wstrb(wstrb[1:0]),
    .addr(addr), .din(din[15:0]), .dout(dout1), .ready(ready1), .err(err1)
  );

  mem_wait #(.DATA_WIDTH(32), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .vaild(vaild2), .wstrb(wstrb),
    .addr(addr), .din(din), .dout(dout2), .ready(ready2), .err(err2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Route the selected instance's outputs to one set of observed signals.
  always_comb begin
    obs_dout  = 32'h0;
    obs_ready = 1'b0;
    obs_err   = 1'b0;
    case (sel)
      0: begin obs_dout = {16'h0, dout0}; obs_ready = ready0; obs_err = err0; end
      1: begin obs_dout = {16'h0, dout1}; obs_ready = ready1; obs_err = err1; end
      2: begin obs_dout = dout2;          obs_ready = ready2; obs_err = err2; end
      default: ;
    endcase
  end

  function automatic int lat_of(input int s);
    case (s)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops the oldest expected response and compares it with what the DUT gave.
  task automatic checkOutput(input int act_lat, input bit timed_out);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (timed_out) begin
      check_val({e.name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_val({e.name, "_latency"}, 32'(act_lat), 32'(e.lat));
    check_val({e.name, "_err"},     {31'h0, obs_err}, {31'h0, e.err});
    check_val({e.name, "_dout"},    obs_dout, e.dout);
  endtask

  // Issues one request, scrambles the bus after accept, waits for ready,
  // keeps vaild high for hold extra clocks, then releases the request.
  task automatic applyStimulus(input string name, input int s,
                               input logic [15:0] a, input logic [3:0] strb,
                               input logic [31:0] d, input logic e_err,
                               input logic [31:0] e_dout, input int hold);
    exp_t e;
    int   k;
    bit   got;
    @(negedge clk);
    sel   = s;
    addr  = a;
    wstrb = strb;
    din   = d;
    vaild = 1'b1;
    e.name = name;
    e.lat  = lat_of(s);
    e.err  = e_err;
    e.dout = e_dout;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    addr  = 16'($urandom);
    wstrb = 4'($urandom);
    din   = $urandom;
    k   = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (obs_ready) got = 1'b1;
    end
    checkOutput(k, !got);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val({name, "_hold_ready"}, {31'h0, obs_ready}, 32'd1);
    end
    vaild = 1'b0;
    @(posedge clk);
    #1;
    check_val({name, "_release"}, {30'h0, obs_ready, obs_err}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    vaild = 1'b0;
    sel   = 0;
    addr  = 16'h0;
    wstrb = 4'h0;
    din   = 32'h0;

    //          sel addr      strb   din            err   dout
    vecs[0]  = '{0, 16'h0000, 4'h3, 32'h0000dead, 1'b0, 32'h00000000};
    vecs[1]  = '{0, 16'h0000, 4'h0, 32'h00000000, 1'b0, 32'h0000dead};
    vecs[2]  = '{0, 16'h0002, 4'h3, 32'h0000beef, 1'b0, 32'h0000dead};
    vecs[3]  = '{0, 16'h0002, 4'h2, 32'h000012aa, 1'b0, 32'h0000dead};
    vecs[4]  = '{0, 16'h0002, 4'h0, 32'h00000000, 1'b0, 32'h000012ef};
    vecs[5]  = '{0, 16'h5000, 4'h0, 32'h00000000, 1'b1, 32'h00000000};
    vecs[6]  = '{0, 16'h0001, 4'h3, 32'h0000ffff, 1'b1, 32'h00000000};
    vecs[7]  = '{0, 16'h0000, 4'h0, 32'h00000000, 1'b0, 32'h0000dead};
    vecs[8]  = '{0, 16'h4ffe, 4'h3, 32'h00005a5a, 1'b0, 32'h0000dead};
    vecs[9]  = '{0, 16'h4ffe, 4'h0, 32'h00000000, 1'b0, 32'h00005a5a};
    vecs[10] = '{0, 16'h4fff, 4'h3, 32'h00000000, 1'b1, 32'h00005a5a};
    vecs[11] = '{0, 16'hfffe, 4'h0, 32'h00000000, 1'b1, 32'h00000000};
    vecs[12] = '{0, 16'h0000, 4'h0, 32'h00000000, 1'b0, 32'h0000dead};
    vecs[13] = '{2, 16'h0008, 4'hf, 32'h01234567, 1'b0, 32'h00000000};
    vecs[14] = '{2, 16'h0008, 4'h0, 32'h00000000, 1'b0, 32'h01234567};
    vecs[15] = '{2, 16'h000a, 4'hf, 32'hffffffff, 1'b1, 32'h01234567};
    vecs[16] = '{2, 16'h0008, 4'h5, 32'haabbccdd, 1'b0, 32'h01234567};
    vecs[17] = '{2, 16'h0008, 4'h0, 32'h00000000, 1'b0, 32'h01bb45dd};
    vecs[18] = '{1, 16'h0004, 4'h3, 32'h00001111, 1'b0, 32'h00000000};
    vecs[19] = '{1, 16'h0004, 4'h0, 32'h00000000, 1'b0, 32'h00001111};
    vecs[20] = '{1, 16'h0006, 4'h3, 32'h00003333, 1'b0, 32'h00001111};
    vecs[21] = '{1, 16'h0006, 4'h0, 32'h00000000, 1'b0, 32'h00003333};

    // Reset state of all three instances.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dut0", {dout0, 14'h0, ready0, err0}, 32'h0);
    check_val("rst_dut1", {dout1, 14'h0, ready1, err1}, 32'h0);
    check_val("rst_dut2_dout", dout2, 32'h0);
    check_val("rst_dut2_flags", {30'h0, ready2, err2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].addr,
                    vecs[i].wstrb, vecs[i].din, vecs[i].exp_err,
                    vecs[i].exp_dout, 0);
    end

    // Abort: vaild drops during the wait states of a write.
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      sel   = 1;
      addr  = 16'h0004;
      wstrb = 4'h3;
      din   = 32'h0000cafe;
      vaild = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vaild = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (obs_ready) seen = 1'b1;
      end
      check_val("abort_no_ready", {31'h0, seen}, 32'd0);
      applyStimulus("abort_readback", 1, 16'h0004, 4'h0, 32'h0, 1'b0,
                    32'h00001111, 0);
    end

    // Held vaild: ten clocks high give one response, no reissue afterwards.
    begin
      bit seen;
      seen = 1'b0;
      applyStimulus("hold_read", 0, 16'h0000, 4'h0, 32'h0, 1'b0,
                    32'h0000dead, 8);
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        if (obs_ready) seen = 1'b1;
      end
      check_val("hold_single_txn", {31'h0, seen}, 32'd0);
    end

    // Reset in the middle of a write's wait states.
    @(negedge clk);
    sel   = 1;
    addr  = 16'h0006;
    wstrb = 4'h3;
    din   = 32'h00007777;
    vaild = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_flags", {30'h0, obs_ready, obs_err}, 32'd0);
    check_val("midrst_dout", obs_dout, 32'h0);
    @(negedge clk);
    vaild = 1'b0;
    rst_n = 1'b1;
    applyStimulus("midrst_readback", 1, 16'h0006, 4'h0, 32'h0, 1'b0,
                  32'h00003333, 0);

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
